// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and loads the
// IF/ID register, handling stall, redirect, halt and out-of-range fetch faults.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  input  logic        HALT_REQ,
  output logic [31:0] ROM_ADDR,
  input  logic [31:0] ROM_DATA,
  output logic [31:0] INSTR,
  output logic [31:0] PC_PLUS4,
  output logic        VALID,
  output logic [31:0] PC,
  output logic        HALTED,
  output logic        ADDR_ERR,
  output logic [31:0] FETCH_COUNT
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [31:0] ROM_LIMIT = 32'(ROM_WORDS);

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] pc_plus4_r;
  logic        valid_r;
  logic        halted_r;
  logic        addr_err_r;
  logic [31:0] fetch_count_r;

  // A word index at or beyond the ROM depth has no backing instruction.
  function automatic logic addr_out_of_range(input logic [31:0] pc);
    return ({2'b00, pc[31:2]} >= ROM_LIMIT);
  endfunction

  // ROM is addressed by word, straight from the PC register.
  assign ROM_ADDR    = {2'b00, pc_r[31:2]};
  assign PC          = pc_r;
  assign INSTR       = instr_r;
  assign PC_PLUS4    = pc_plus4_r;
  assign VALID       = valid_r;
  assign HALTED      = halted_r;
  assign ADDR_ERR    = addr_err_r;
  assign FETCH_COUNT = fetch_count_r;

  // Fetch FSM, PC and IF/ID register update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r       <= ST_RUN;
      pc_r          <= RESET_PC;
      instr_r       <= 32'h0000_0000;
      pc_plus4_r    <= 32'h0000_0000;
      valid_r       <= 1'b0;
      halted_r      <= 1'b0;
      addr_err_r    <= 1'b0;
      fetch_count_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (HALT_REQ) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
            instr_r  <= 32'h0000_0000;
            valid_r  <= 1'b0;
          end else if (REDIRECT) begin
            // Redirect flushes the slot being fetched and wins over a stall.
            pc_r    <= REDIRECT_PC & 32'hFFFF_FFFC;
            instr_r <= 32'h0000_0000;
            valid_r <= 1'b0;
          end else if (STALL) begin
            pc_r <= pc_r;
          end else if (addr_out_of_range(pc_r)) begin
            state_r    <= ST_FAULT;
            halted_r   <= 1'b1;
            addr_err_r <= 1'b1;
            instr_r    <= 32'h0000_0000;
            valid_r    <= 1'b0;
          end else begin
            instr_r       <= ROM_DATA;
            pc_plus4_r    <= pc_r + 32'd4;
            valid_r       <= 1'b1;
            pc_r          <= pc_r + 32'd4;
            fetch_count_r <= fetch_count_r + 32'd1;
          end
        end
        ST_HALT, ST_FAULT: begin
          state_r <= state_r;
        end
        default: begin
          // Unreachable encoding: park in FAULT with a bubble in IF/ID.
          state_r    <= ST_FAULT;
          halted_r   <= 1'b1;
          addr_err_r <= 1'b1;
          instr_r    <= 32'h0000_0000;
          valid_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run, all
// checked against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        STALL = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic        HALT_REQ = 1'b0;
  logic [31:0] ROM_ADDR;
  logic [31:0] ROM_DATA;
  logic [31:0] INSTR;
  logic [31:0] PC_PLUS4;
  logic        VALID;
  logic [31:0] PC;
  logic        HALTED;
  logic        ADDR_ERR;
  logic [31:0] FETCH_COUNT;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] rom [0:255];

  fetch_unit #(.RESET_PC(32'h0000_0000), .ROM_WORDS(256)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .HALT_REQ(HALT_REQ), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA), .INSTR(INSTR),
    .PC_PLUS4(PC_PLUS4), .VALID(VALID), .PC(PC), .HALTED(HALTED), .ADDR_ERR(ADDR_ERR),
    .FETCH_COUNT(FETCH_COUNT)
  );

  always #5 CLK = ~CLK;

  assign ROM_DATA = (ROM_ADDR < 32'd256) ? rom[ROM_ADDR[7:0]] : 32'hDEAD_BEEF;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_halted, m_err;
  bit          m_stopped;

  task automatic model_edge();
    if (RST) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_count = 32'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_err = 1'b0; m_stopped = 1'b0;
    end else if (m_stopped) begin
      m_stopped = 1'b1;
    end else if (HALT_REQ) begin
      m_stopped = 1'b1; m_halted = 1'b1; m_valid = 1'b0; m_instr = 32'h0;
    end else if (REDIRECT) begin
      m_pc = (REDIRECT_PC / 4) * 4; m_valid = 1'b0; m_instr = 32'h0;
    end else if (STALL) begin
      m_stopped = 1'b0;
    end else if (m_pc / 4 >= 256) begin
      m_stopped = 1'b1; m_halted = 1'b1; m_err = 1'b1; m_valid = 1'b0; m_instr = 32'h0;
    end else begin
      m_instr = rom[m_pc / 4];
      m_pc4 = m_pc + 4;
      m_pc = m_pc + 4;
      m_valid = 1'b1;
      m_count = m_count + 1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [162:0] dut_vec();
    return {ROM_ADDR, PC, INSTR, PC_PLUS4, FETCH_COUNT, VALID, HALTED, ADDR_ERR};
  endfunction

  function automatic logic [162:0] mdl_vec();
    return {m_pc / 32'd4, m_pc, m_instr, m_pc4, m_count, m_valid, m_halted, m_err};
  endfunction

  task automatic idle_inputs();
    RST = 1'b0; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0; HALT_REQ = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; STALL = 1'b1; REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0080; HALT_REQ = 1'b1;
    tick();
    compared++;
    if (dut_vec() !== mdl_vec()) begin
      mismatched++;
      $display("FAIL reset_state got %h exp %h", dut_vec(), mdl_vec());
    end
    compared++;
    if ({PC, VALID, HALTED, FETCH_COUNT} !== {32'h0, 1'b0, 1'b0, 32'h0}) begin
      mismatched++;
      $display("FAIL reset_const got pc=%h v=%b h=%b cnt=%0d exp pc=0 v=0 h=0 cnt=0", PC, VALID, HALTED, FETCH_COUNT);
    end
    idle_inputs();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_i [4];
    exp_i[0] = 32'h2008_0001; exp_i[1] = 32'h2009_0002; exp_i[2] = 32'h0109_5020; exp_i[3] = 32'hAC0A_0000;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      compared++;
      if ({INSTR, PC_PLUS4, VALID} !== {exp_i[i], 32'(4 * (i + 1)), 1'b1} || dut_vec() !== mdl_vec()) begin
        mismatched++;
        $display("FAIL seq_fetch%0d got instr=%h pc4=%h v=%b exp instr=%h pc4=%h v=1", i, INSTR, PC_PLUS4, VALID, exp_i[i], 32'(4 * (i + 1)));
      end
    end
    compared++;
    if (FETCH_COUNT !== 32'd4) begin
      mismatched++;
      $display("FAIL seq_count got %0d exp 4", FETCH_COUNT);
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if ({INSTR, PC, FETCH_COUNT} !== {32'h2009_0002, 32'h8, 32'd2} || dut_vec() !== mdl_vec()) begin
        mismatched++;
        $display("FAIL stall_hold%0d got instr=%h pc=%h cnt=%0d exp instr=20090002 pc=8 cnt=2", i, INSTR, PC, FETCH_COUNT);
      end
    end
    STALL = 1'b0;
    tick();
    compared++;
    if ({INSTR, VALID, FETCH_COUNT} !== {32'h0109_5020, 1'b1, 32'd3}) begin
      mismatched++;
      $display("FAIL stall_release got instr=%h v=%b cnt=%0d exp instr=01095020 v=1 cnt=3", INSTR, VALID, FETCH_COUNT);
    end
  endtask

  task automatic test_redirect_vs_stall();
    do_reset();
    tick();
    REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0041; STALL = 1'b1;
    tick();
    idle_inputs();
    compared++;
    if ({VALID, PC} !== {1'b0, 32'h40} || dut_vec() !== mdl_vec()) begin
      mismatched++;
      $display("FAIL redir_bubble got v=%b pc=%h exp v=0 pc=40", VALID, PC);
    end
    tick();
    compared++;
    if ({INSTR, VALID, PC_PLUS4} !== {rom[16], 1'b1, 32'h44}) begin
      mismatched++;
      $display("FAIL redir_target got instr=%h v=%b pc4=%h exp instr=%h v=1 pc4=44", INSTR, VALID, PC_PLUS4, rom[16]);
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    HALT_REQ = 1'b1;
    tick();
    HALT_REQ = 1'b0;
    compared++;
    if ({VALID, HALTED, PC, FETCH_COUNT} !== {1'b0, 1'b1, 32'h10, 32'd4}) begin
      mismatched++;
      $display("FAIL halt_enter got v=%b h=%b pc=%h cnt=%0d exp v=0 h=1 pc=10 cnt=4", VALID, HALTED, PC, FETCH_COUNT);
    end
    for (int i = 0; i < 20; i++) begin
      REDIRECT = 1'($urandom_range(0, 1)); STALL = 1'($urandom_range(0, 1));
      HALT_REQ = 1'($urandom_range(0, 1)); REDIRECT_PC = $urandom_range(0, 255) * 4;
      tick();
      compared++;
      if ({PC, HALTED, VALID} !== {32'h10, 1'b1, 1'b0} || dut_vec() !== mdl_vec()) begin
        mismatched++;
        $display("FAIL halt_frozen%0d got pc=%h h=%b v=%b exp pc=10 h=1 v=0", i, PC, HALTED, VALID);
      end
    end
    idle_inputs();
  endtask

  task automatic test_out_of_range();
    do_reset();
    tick();
    REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0400;
    tick();
    idle_inputs();
    compared++;
    if ({VALID, HALTED, ADDR_ERR, PC} !== {1'b0, 1'b0, 1'b0, 32'h400}) begin
      mismatched++;
      $display("FAIL oor_bubble got v=%b h=%b err=%b pc=%h exp v=0 h=0 err=0 pc=400", VALID, HALTED, ADDR_ERR, PC);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if ({ADDR_ERR, HALTED, VALID, PC, FETCH_COUNT} !== {1'b1, 1'b1, 1'b0, 32'h400, 32'd1}) begin
        mismatched++;
        $display("FAIL oor_fault%0d got err=%b h=%b v=%b pc=%h cnt=%0d exp err=1 h=1 v=0 pc=400 cnt=1", i, ADDR_ERR, HALTED, VALID, PC, FETCH_COUNT);
      end
      REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0020;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_fault();
    STALL = 1'b1; REDIRECT = 1'b1; RST = 1'b1;
    tick();
    idle_inputs();
    compared++;
    if ({PC, INSTR, PC_PLUS4, VALID, HALTED, ADDR_ERR, FETCH_COUNT} !== 131'h0) begin
      mismatched++;
      $display("FAIL fault_reset got %h exp all zero", {PC, INSTR, PC_PLUS4, VALID, HALTED, ADDR_ERR, FETCH_COUNT});
    end
    tick();
    compared++;
    if ({INSTR, VALID, PC} !== {32'h2008_0001, 1'b1, 32'h4}) begin
      mismatched++;
      $display("FAIL fault_resume got instr=%h v=%b pc=%h exp instr=20080001 v=1 pc=4", INSTR, VALID, PC);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      RST = ($urandom_range(0, 99) < 3);
      STALL = ($urandom_range(0, 99) < 25);
      REDIRECT = ($urandom_range(0, 99) < 10);
      REDIRECT_PC = $urandom_range(0, 32'h43F);
      HALT_REQ = ($urandom_range(0, 99) < 2);
      tick();
      compared++;
      if (dut_vec() !== mdl_vec()) begin
        mismatched++;
        $display("FAIL random%0d got %h exp %h", i, dut_vec(), mdl_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h2008_0001; rom[1] = 32'h2009_0002; rom[2] = 32'h0109_5020; rom[3] = 32'hAC0A_0000;
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_count = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_err = 1'b0; m_stopped = 1'b0;
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_vs_stall();
    test_halt();
    test_out_of_range();
    test_reset_mid_fault();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-issue MIPS pipeline, directly upstream of the instruction ROM. Holds the program counter, drives the ROM word address, captures the returned 32-bit instruction into the IF/ID register, and handles stall, branch/jump redirect, halt and out-of-range fetch. The decode stage reads its registered outputs.

## Interface
- RESET_PC, 32'h0000_0000: byte address loaded into PC on reset; must be word-aligned.
- ROM_WORDS, 256: instruction ROM depth in 32-bit words; must be a power of two.
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- STALL  input  1  hazard-unit hold: PC and IF/ID keep their values.
- REDIRECT  input  1  taken branch or jump resolved downstream.
- REDIRECT_PC  input  32  byte target for REDIRECT.
- HALT_REQ  input  1  stop fetching after the current cycle.
- ROM_ADDR  output  32  word index to ROM: {2'b00, PC[31:2]}, combinational from the PC register.
- ROM_DATA  input  32  instruction returned combinationally by ROM for ROM_ADDR.
- INSTR  output  32  IF/ID instruction register.
- PC_PLUS4  output  32  IF/ID copy of fetch PC + 4.
- VALID  output  1  INSTR/PC_PLUS4 hold a real instruction (0 = bubble).
- PC  output  32  current fetch PC.
- HALTED  output  1  state is HALT or FAULT.
- ADDR_ERR  output  1  sticky out-of-range fetch flag.
- FETCH_COUNT  output  32  number of instructions captured with VALID=1.

## Operation
- FSM states: RUN, HALT, FAULT. Reset state RUN.
- Out-of-range: PC >= ROM_WORDS*4, i.e. PC[31:2] >= ROM_WORDS.
- RUN priority per edge (highest first):
  1. HALT_REQ: go HALT; IF/ID loads bubble (VALID=0, INSTR=0); PC holds.
  2. REDIRECT: PC <= {REDIRECT_PC[31:2],2'b00} (low bits dropped); IF/ID loads bubble (flush). Overrides STALL.
  3. STALL: PC, INSTR, PC_PLUS4, VALID, FETCH_COUNT all hold.
  4. Out-of-range PC: go FAULT; ADDR_ERR <= 1; IF/ID loads bubble; PC holds; ROM_DATA ignored.
  5. Normal: INSTR <= ROM_DATA; PC_PLUS4 <= PC+4; VALID <= 1; PC <= PC+4; FETCH_COUNT += 1.
- HALT, FAULT: PC, IF/ID (bubble), FETCH_COUNT frozen; all inputs except RST ignored. Exit only by RST.
- PC+4 is modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000); with default ROM_WORDS the out-of-range check fires first.
- FETCH_COUNT wraps modulo 2^32.
- A REDIRECT to an out-of-range target is accepted; the fault is raised the following cycle (rule 4).

## Timing
- Reset values (edge with RST=1, any state, any other inputs): PC=RESET_PC, INSTR=0, PC_PLUS4=0, VALID=0, ADDR_ERR=0, FETCH_COUNT=0, state RUN, HALTED=0.
- ROM_ADDR follows PC combinationally; ROM_DATA sampled at the same edge that advances PC.
- Latency: instruction at PC appears on INSTR one edge after PC holds that value; first VALID=1 at the first edge after RST deasserts (no stall).
- Redirect penalty: one bubble cycle (the flushed slot), then target instruction on the following edge.
- Stall of N cycles: outputs frozen exactly N edges; no instruction lost or duplicated.
- HALTED asserts the edge after HALT_REQ or fault detection.
- RST mid-operation (including during STALL, REDIRECT, HALT, FAULT) wins unconditionally.

## Test plan
- Sequential fetch: RST 1 cycle, ROM words 0..3 = 0x20080001, 0x20090002, 0x01095020, 0xAC0A0000 -> INSTR shows them on edges 1..4, PC_PLUS4 = 4,8,12,16, FETCH_COUNT=4.
- Stall: STALL high 3 cycles after second fetch -> INSTR stays 0x20090002, PC stays 8 for 3 edges, then 0x01095020; FETCH_COUNT unchanged during stall.
- Redirect vs stall: REDIRECT=1, REDIRECT_PC=0x0000_0041, STALL=1 same cycle -> VALID=0 next edge, PC=0x40, then INSTR=ROM word 16.
- Halt: HALT_REQ one cycle at PC=0x10 -> VALID=0, HALTED=1, PC stays 0x10 for 20 cycles regardless of REDIRECT/STALL.
- Out-of-range: REDIRECT_PC=0x400 with ROM_WORDS=256 -> one bubble, then ADDR_ERR=1, HALTED=1, PC=0x400, FETCH_COUNT frozen.
- Reset mid-fault: RST in FAULT -> all outputs at reset values next edge; fetch resumes at RESET_PC.
